// File: rtl/score_pkg.sv
// Shared types and widths for the score player: sequencer states and note/length field sizes.
package score_pkg;

  localparam int unsigned NoteW = 5;
  localparam int unsigned LenW  = 2;

  localparam logic [NoteW-1:0] REST_NOTE = 5'd0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StPlay,
    StGap,
    StAdvance,
    StDone
  } state_e;

endpackage

// File: rtl/beat_timer.sv
// Note-duration timer: counts BEAT_CYCLES clocks per beat and flags the final cycle of
// a note lasting len+1 beats.
module beat_timer
  import score_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 12500000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [LenW-1:0] len,
  input  logic            en,
  output logic            last
);

  // A single-cycle beat still needs one counter bit to keep the ports legal.
  localparam int unsigned CycW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(BEAT_CYCLES - 1);

  logic [CycW-1:0] cyc_q, cyc_d;
  logic [LenW-1:0] beat_q, beat_d;
  logic            cyc_wrap;

  assign cyc_wrap = (cyc_q == CycLast);

  always_comb begin
    cyc_d  = cyc_q;
    beat_d = beat_q;
    if (load) begin
      cyc_d  = '0;
      beat_d = '0;
    end else if (en) begin
      cyc_d = cyc_wrap ? '0 : cyc_q + 1'b1;
      if (cyc_wrap) begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= '0;
      beat_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      beat_q <= beat_d;
    end
  end

  assign last = en && cyc_wrap && (beat_q == len);

endmodule

// File: rtl/score_player.sv
// Score sequencer: walks the score memory, holds each note for its encoded length, inserts an
// articulation gap, and supports one-shot or looped playback.
module score_player
  import score_pkg::*;
#(
  parameter int unsigned audio_len   = 6,
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic                 Done_gen_score,
  input  logic [NoteW-1:0]     note,
  input  logic [LenW-1:0]      length,
  output logic [audio_len-1:0] score_noteAdr,
  output logic [NoteW-1:0]     play_note,
  output logic                 note_on,
  output logic                 playing,
  output logic                 done
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0]      GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [audio_len-1:0] AdrLast = '1;

  state_e               state_q, state_d;
  logic [LenW-1:0]      cur_len_q, cur_len_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [audio_len-1:0] adr_q, adr_d;
  logic [NoteW-1:0]     play_note_q, play_note_d;
  logic                 note_on_q, note_on_d;
  logic                 playing_q, playing_d;
  logic                 done_q, done_d;
  logic                 beat_last;

  beat_timer #(
    .BEAT_CYCLES(BEAT_CYCLES)
  ) u_beat_timer (
    .clk  (clk),
    .reset(reset),
    .load (state_q == StLoad),
    .len  (cur_len_q),
    .en   (state_q == StPlay),
    .last (beat_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_len_q   <= '0;
      gap_q       <= '0;
      adr_q       <= '0;
      play_note_q <= '0;
      note_on_q   <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_len_q   <= cur_len_d;
      gap_q       <= gap_d;
      adr_q       <= adr_d;
      play_note_q <= play_note_d;
      note_on_q   <= note_on_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start && Done_gen_score) state_d = StFetch;
      StFetch:   state_d = StLoad;
      StLoad:    state_d = StPlay;
      StPlay:    if (beat_last) state_d = (GAP_CYCLES == 0) ? StAdvance : StGap;
      StGap:     if (gap_q == GapLast) state_d = StAdvance;
      StAdvance: state_d = ((adr_q != AdrLast) || loop) ? StFetch : StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // Abort wins over every transition, including a start in idle.
    if (stop) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    adr_d       = adr_q;
    play_note_d = play_note_q;
    cur_len_d   = cur_len_q;
    gap_d       = '0;
    unique case (state_q)
      StLoad: begin
        if (!stop) begin
          play_note_d = note;
          cur_len_d   = length;
        end
      end
      StGap:     gap_d = gap_q + 1'b1;
      StAdvance: begin
        if (adr_q != AdrLast) begin
          adr_d = adr_q + 1'b1;
        end else if (loop) begin
          adr_d = '0;
        end
      end
      default: ;
    endcase
    if (state_d == StIdle) begin
      adr_d = '0;
    end
    note_on_d = (state_d == StPlay) &&
                ((state_q == StLoad) ? (note != REST_NOTE) : note_on_q);
    playing_d = !((state_d == StIdle) || (state_d == StDone));
    done_d    = (state_d == StDone);
  end

  assign score_noteAdr = adr_q;
  assign play_note     = play_note_q;
  assign note_on       = note_on_q;
  assign playing       = playing_q;
  assign done          = done_q;

endmodule

// File: tb/tb_score_player.sv
// Bench for score_player: a gapped and a gap-free instance share stimulus and are compared each
// cycle with a note-slot timeline model, plus a segment table and directed corner cases.
module tb_score_player;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset, start, stop, loop, dgs;
  logic [1:0] a_adr [2];
  logic [4:0] a_pn  [2];
  logic       a_on  [2];
  logic       a_pl  [2];
  logic       a_dn  [2];
  logic [4:0] m_note[2];
  logic [1:0] m_len [2];

  logic [4:0] rom_note [4] = '{5'd5, 5'd0, 5'd12, 5'd31};
  logic [1:0] rom_len  [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

  always #5 clk = ~clk;

  score_player #(.audio_len(2), .BEAT_CYCLES(B), .GAP_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop), .Done_gen_score(dgs),
    .note(m_note[0]), .length(m_len[0]), .score_noteAdr(a_adr[0]), .play_note(a_pn[0]),
    .note_on(a_on[0]), .playing(a_pl[0]), .done(a_dn[0])
  );

  score_player #(.audio_len(2), .BEAT_CYCLES(B), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop), .Done_gen_score(dgs),
    .note(m_note[1]), .length(m_len[1]), .score_noteAdr(a_adr[1]), .play_note(a_pn[1]),
    .note_on(a_on[1]), .playing(a_pl[1]), .done(a_dn[1])
  );

  // Score memory with one-cycle read latency.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_note[i] <= rom_note[a_adr[i]];
      m_len[i]  <= rom_len[a_adr[i]];
    end
  end

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;

  // Model: mode 0 idle, 1 playing a note slot, 2 done pulse.
  // A slot runs FETCH(0), LOAD(1), sounding offsets 2..2+D-1, gap, then ADVANCE as last offset.
  int m_mode[2];
  int m_adr [2];
  int m_off [2];
  int m_pn  [2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int dur_of(input int a);
    return (int'(rom_len[a]) + 1) * B;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = 0; m_adr[i] = 0; m_off[i] = 0; m_pn[i] = 0;
      end else if (stop) begin
        m_mode[i] = 0; m_adr[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (start && dgs) begin
          m_mode[i] = 1; m_adr[i] = 0; m_off[i] = 0;
        end
      end else if (m_mode[i] == 1) begin
        if (m_off[i] == 2 + dur_of(m_adr[i]) + gap_of(i)) begin
          if (m_adr[i] != 3) begin
            m_adr[i]++; m_off[i] = 0;
          end else if (loop) begin
            m_adr[i] = 0; m_off[i] = 0;
          end else begin
            m_mode[i] = 2;
          end
        end else begin
          m_off[i]++;
          if (m_off[i] == 2) m_pn[i] = int'(rom_note[m_adr[i]]);
        end
      end else begin
        m_mode[i] = 0; m_adr[i] = 0;
      end
    end
  endtask

  task automatic compare();
    int e_on;
    for (int i = 0; i < 2; i++) begin
      e_on = (m_mode[i] == 1 && m_off[i] >= 2 && m_off[i] < 2 + dur_of(m_adr[i]) &&
              rom_note[m_adr[i]] != 5'd0) ? 1 : 0;
      chk($sformatf("dut%0d adr", i), a_adr[i], m_adr[i]);
      chk($sformatf("dut%0d play_note", i), a_pn[i], m_pn[i]);
      chk($sformatf("dut%0d note_on", i), a_on[i], e_on);
      chk($sformatf("dut%0d playing", i), a_pl[i], (m_mode[i] == 1) ? 1 : 0);
      chk($sformatf("dut%0d done", i), a_dn[i], (m_mode[i] == 2) ? 1 : 0);
    end
    if (a_dn[0] === 1'b1) done_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  typedef struct {
    int   n;
    int   pn;
    logic on;
    logic pl;
    logic dn;
    int   adr;
  } seg_t;

  seg_t segs[14];
  int   low_run;
  bit   found;

  initial begin
    segs = '{
      '{2, 0, 0, 1, 0, 0}, '{4, 5, 1, 1, 0, 0}, '{3, 5, 0, 1, 0, 0},
      '{2, 5, 0, 1, 0, 1}, '{8, 0, 0, 1, 0, 1}, '{3, 0, 0, 1, 0, 1},
      '{2, 0, 0, 1, 0, 2}, '{16, 12, 1, 1, 0, 2}, '{3, 12, 0, 1, 0, 2},
      '{2, 12, 0, 1, 0, 3}, '{12, 31, 1, 1, 0, 3}, '{3, 31, 0, 1, 0, 3},
      '{1, 31, 0, 0, 1, 3}, '{2, 31, 0, 0, 0, 0}
    };
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; dgs = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset adr", a_adr[0], 0);
    chk("reset play_note", a_pn[0], 0);
    chk("reset playing", a_pl[0], 0);

    // One-shot pass checked segment by segment on the gapped instance.
    pulse_start();
    for (int s = 0; s < 14; s++) begin
      for (int k = 0; k < segs[s].n; k++) begin
        if (!(s == 0 && k == 0)) step();
        chk($sformatf("t1 seg%0d pn", s), a_pn[0], segs[s].pn);
        chk($sformatf("t1 seg%0d on", s), a_on[0], segs[s].on);
        chk($sformatf("t1 seg%0d playing", s), a_pl[0], segs[s].pl);
        chk($sformatf("t1 seg%0d done", s), a_dn[0], segs[s].dn);
        chk($sformatf("t1 seg%0d adr", s), a_adr[0], segs[s].adr);
      end
    end

    // Start ignored while the score is not generated.
    dgs = 1'b0;
    pulse_start();
    repeat (4) step();
    chk("nogen playing", a_pl[0], 0);
    chk("nogen adr", a_adr[0], 0);
    dgs = 1'b1;

    // Looped playback wraps to address 0 with no done pulse.
    loop = 1'b1;
    done_cnt = 0;
    pulse_start();
    repeat (64) step();
    chk("loop wrap pn", a_pn[0], 5);
    chk("loop wrap adr", a_adr[0], 0);
    chk("loop wrap on", a_on[0], 1);
    repeat (5) step();
    chk("loop done count", done_cnt, 0);
    chk("loop playing", a_pl[0], 1);
    loop = 1'b0;
    stop = 1'b1; step(); stop = 1'b0; step();

    // Stop on the second sounding cycle of the third note.
    pulse_start();
    repeat (25) step();
    chk("pre-stop pn", a_pn[0], 12);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop on", a_on[0], 0);
    chk("stop adr", a_adr[0], 0);
    chk("stop playing", a_pl[0], 0);
    chk("stop done", a_dn[0], 0);
    done_cnt = 0;
    repeat (30) step();
    chk("stop no done", done_cnt, 0);
    pulse_start();
    repeat (2) step();
    chk("replay pn", a_pn[0], 5);
    chk("replay on", a_on[0], 1);
    chk("replay adr", a_adr[0], 0);
    stop = 1'b1; step(); stop = 1'b0;

    // Reset in the first gap, then start hammered during playback.
    pulse_start();
    repeat (6) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst adr", a_adr[0], 0);
    chk("rst pn", a_pn[0], 0);
    chk("rst on", a_on[0], 0);
    chk("rst playing", a_pl[0], 0);
    chk("rst done", a_dn[0], 0);
    pulse_start();
    for (int k = 0; k < 60; k++) begin
      start = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;

    // Gap-free instance: only the three bookkeeping cycles separate notes 3 and 4.
    pulse_start();
    low_run = 0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (a_on[1] !== 1'b1) begin
        low_run++;
      end else begin
        if (low_run > 0 && a_pn[1] == 5'd31) begin
          chk("gap0 low run", low_run, 3);
          found = 1'b1;
        end
        low_run = 0;
      end
    end
    if (!found) chk("gap0 note4 seen", 0, 1);
    repeat (80) step();

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 7) == 0);
      dgs   = ($urandom_range(0, 9) != 0);
      if (k % 50 == 0) loop = 1'($urandom_range(0, 1));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
